inst_queue: RTL and testbench

In-order instruction queue between the decoder and `dispatcher`. It buffers `DECODED_PACK` entries, presents the oldest one to the dispatcher, and retires it only when the dispatcher and ROB accept it. It also generates the front-end stall and empties itself on a branch-mispredict squash.

---
 rtl/inst_queue_pkg.sv | 25 ++
 rtl/inst_queue.sv | 92 +++++++++
 tb/tb_inst_queue.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types for the in-order instruction queue: the decoded instruction
// pack carried from decoder to dispatcher and the default queue geometry.
package inst_queue_pkg;

    localparam int IQ_DEPTH_DEFAULT   = 8;
    localparam int IQ_PTR_LEN_DEFAULT = $clog2(IQ_DEPTH_DEFAULT);

    // Head/tail pointer: index bits plus one wrap bit.
    typedef logic [IQ_PTR_LEN_DEFAULT:0] IQ_PTR;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_MEM = 2'd2,
        FU_BR  = 2'd3
    } fu_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        fu_e         fu;
        logic [4:0]  dest_reg;
    } DECODED_PACK;

endpackage

// File: rtl/inst_queue.sv
// In-order instruction queue between decoder and dispatcher. Buffers decoded
// packs in a circular flop array, shows the oldest entry to the dispatcher and
// retires it when neither the dispatcher nor the ROB stalls. A squash empties
// the queue; reset additionally clears the stored entries.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int IQ_DEPTH   = IQ_DEPTH_DEFAULT,
    parameter int IQ_PTR_LEN = $clog2(IQ_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  DECODED_PACK           decoded_pack,
    input  logic                  decoded_valid,
    input  logic                  dispatch_stall,
    input  logic                  rob_full,
    input  logic                  squash,
    output DECODED_PACK           dispatch_pack,
    output logic                  dispatch_valid,
    output logic                  dispatch_fire,
    output logic                  iq_full,
    output logic [IQ_PTR_LEN:0]   iq_count
);

    localparam logic [IQ_PTR_LEN:0] PTR_ONE   = (IQ_PTR_LEN + 1)'(1);
    localparam logic [IQ_PTR_LEN:0] PTR_ZERO  = (IQ_PTR_LEN + 1)'(0);
    localparam logic [IQ_PTR_LEN:0] DEPTH_CNT = (IQ_PTR_LEN + 1)'(IQ_DEPTH);

    DECODED_PACK         entries_r [IQ_DEPTH];
    logic [IQ_PTR_LEN:0] head_r;
    logic [IQ_PTR_LEN:0] tail_r;

    logic [IQ_PTR_LEN:0] count_s;
    logic                full_s;
    logic                valid_s;
    logic                enq_s;
    logic                fire_s;
    DECODED_PACK         head_pack_s;

    // Occupancy and flags derived purely from the registered pointers; the
    // full test never looks at this cycle's dequeue.
    always_comb begin
        count_s = tail_r - head_r;
        full_s  = (count_s == DEPTH_CNT);
        valid_s = (count_s != PTR_ZERO);
    end

    // Handshakes and show-ahead head read; fire is independent of the pack
    // contents so a stall derived from dispatch_pack.fu cannot form a loop.
    always_comb begin
        enq_s  = decoded_valid & ~full_s & ~squash;
        fire_s = valid_s & ~dispatch_stall & ~rob_full & ~squash;
        if (valid_s) begin
            head_pack_s = entries_r[head_r[IQ_PTR_LEN-1:0]];
        end else begin
            head_pack_s = '0;
        end
    end

    // Pointer and storage update: reset outranks squash, squash outranks traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r <= PTR_ZERO;
            tail_r <= PTR_ZERO;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else if (squash) begin
            head_r <= PTR_ZERO;
            tail_r <= PTR_ZERO;
        end else begin
            if (enq_s) begin
                entries_r[tail_r[IQ_PTR_LEN-1:0]] <= decoded_pack;
                tail_r                            <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            if (fire_s) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
        end
    end

    assign dispatch_pack  = head_pack_s;
    assign dispatch_valid = valid_s;
    assign dispatch_fire  = fire_s;
    assign iq_full        = full_s;
    assign iq_count       = count_s;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: the monitor predicts occupancy, head pack
// and fire from a queue of accepted packs, and directed checks cover the
// scenario-specific points (latency, peak occupancy, squash and reset).
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    DECODED_PACK decoded_pack;
    logic        decoded_valid;
    logic        dispatch_stall;
    logic        rob_full;
    logic        squash;
    DECODED_PACK dispatch_pack;
    logic        dispatch_valid;
    logic        dispatch_fire;
    logic        iq_full;
    logic [3:0]  iq_count;

    inst_queue #(.IQ_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .decoded_pack   (decoded_pack),
        .decoded_valid  (decoded_valid),
        .dispatch_stall (dispatch_stall),
        .rob_full       (rob_full),
        .squash         (squash),
        .dispatch_pack  (dispatch_pack),
        .dispatch_valid (dispatch_valid),
        .dispatch_fire  (dispatch_fire),
        .iq_full        (iq_full),
        .iq_count       (iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    DECODED_PACK sb[$];
    logic        mon_en = 1'b0;
    logic        acc_flag = 1'b0;
    int          peak_cnt = 0;
    int          fire_seen = 0;
    int          fire_run = 0;
    int          fire_run_max = 0;
    logic        rob_run = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic DECODED_PACK mk(input logic [31:0] pc);
        DECODED_PACK p;
        p.pc       = pc;
        p.inst     = pc ^ 32'hA5A5_0013;
        p.fu       = fu_e'(pc[3:2]);
        p.dest_reg = pc[6:2];
        return p;
    endfunction

    // Monitor: compare outputs against the model, then advance the model.
    always @(negedge clk) begin
        if (mon_en) begin
            int   exp_cnt;
            logic exp_fire;
            exp_cnt = sb.size();
            check("iq_count", 64'(iq_count), 64'(exp_cnt));
            check("iq_full", 64'(iq_full), 64'(exp_cnt == DEPTH));
            check("dispatch_valid", 64'(dispatch_valid), 64'(exp_cnt != 0));
            if (exp_cnt != 0) begin
                check("head_pc", 64'(dispatch_pack.pc), 64'(sb[0].pc));
                check("head_fields", 64'(dispatch_pack == sb[0]), 64'd1);
            end else begin
                check("empty_pack_zero", 64'(dispatch_pack != '0), 64'd0);
            end
            exp_fire = (exp_cnt != 0) && !dispatch_stall && !rob_full && !squash;
            check("dispatch_fire", 64'(dispatch_fire), 64'(exp_fire));
            if (int'(iq_count) > peak_cnt) peak_cnt = int'(iq_count);
            if (dispatch_fire === 1'b1) begin
                fire_seen++;
                fire_run++;
                if (fire_run > fire_run_max) fire_run_max = fire_run;
            end else begin
                fire_run = 0;
            end
            if (reset || squash) begin
                sb.delete();
                acc_flag = 1'b0;
            end else begin
                if (exp_fire) void'(sb.pop_front());
                acc_flag = decoded_valid && (exp_cnt < DEPTH);
                if (acc_flag) sb.push_back(decoded_pack);
            end
        end
    end

    // Present a pack and hold it until the model says it was accepted.
    task automatic push(input logic [31:0] pc);
        int n;
        n = 0;
        decoded_pack  = mk(pc);
        decoded_valid = 1'b1;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_flag && n < 40);
        check("push_accept_timeout", 64'(acc_flag), 64'd1);
        #1;
        decoded_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        squash         = 1'b0;
        decoded_valid  = 1'b0;
        decoded_pack   = '0;
        dispatch_stall = 1'b0;
        rob_full       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Three back-to-back packs with no stall.
        peak_cnt = 0; fire_seen = 0; fire_run_max = 0;
        push(32'h0);
        push(32'h4);
        push(32'h8);
        drain();
        check("t1_peak_count", 64'(peak_cnt), 64'd1);
        check("t1_fire_total", 64'(fire_seen), 64'd3);
        check("t1_fire_consecutive", 64'(fire_run_max), 64'd3);

        // Fill under stall, ninth pack is held until space frees.
        dispatch_stall = 1'b1;
        for (int i = 0; i < 8; i++) push(32'(i * 4));
        decoded_pack  = mk(32'h20);
        decoded_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t2_full", 64'(iq_full), 64'd1);
        check("t2_count8", 64'(iq_count), 64'd8);
        check("t2_ninth_refused", 64'(acc_flag), 64'd0);
        @(posedge clk);
        #1;
        dispatch_stall = 1'b0;
        push(32'h20);
        drain();

        // Wrap-around with random single-cycle rob_full pulses.
        rob_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++) push(32'h100 + 32'(i * 4));
                rob_run = 1'b0;
            end
            begin
                while (rob_run) begin
                    @(posedge clk);
                    #1;
                    rob_full = ($urandom_range(0, 2) == 0) && !rob_full;
                end
                rob_full = 1'b0;
            end
        join
        drain();

        // Squash with five entries and a valid incoming pack.
        dispatch_stall = 1'b1;
        for (int i = 0; i < 5; i++) push(32'h200 + 32'(i * 4));
        dispatch_stall = 1'b0;
        squash         = 1'b1;
        decoded_pack   = mk(32'h300);
        decoded_valid  = 1'b1;
        @(negedge clk);
        check("t4_fire_in_squash", 64'(dispatch_fire), 64'd0);
        @(posedge clk);
        #1;
        squash        = 1'b0;
        decoded_valid = 1'b0;
        @(negedge clk);
        check("t4_count_after", 64'(iq_count), 64'd0);
        check("t4_valid_after", 64'(dispatch_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset mid-stream together with squash and a valid pack.
        dispatch_stall = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(i * 4));
        dispatch_stall = 1'b0;
        reset          = 1'b1;
        squash         = 1'b1;
        decoded_pack   = mk(32'h500);
        decoded_valid  = 1'b1;
        @(negedge clk);
        check("t5_count_before", 64'(iq_count), 64'd4);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        squash        = 1'b0;
        decoded_valid = 1'b0;
        @(negedge clk);
        check("t5_count_reset", 64'(iq_count), 64'd0);
        check("t5_valid_reset", 64'(dispatch_valid), 64'd0);
        check("t5_full_reset", 64'(iq_full), 64'd0);
        check("t5_fire_reset", 64'(dispatch_fire), 64'd0);
        check("t5_pack_reset", 64'(dispatch_pack != '0), 64'd0);
        @(posedge clk);
        #1;
        push(32'h600);
        @(negedge clk);
        check("t5_post_valid", 64'(dispatch_valid), 64'd1);
        check("t5_post_pc", 64'(dispatch_pack.pc), 64'h600);
        check("t5_post_fire", 64'(dispatch_fire), 64'd1);
        drain();

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
